// File: rtl/xillybus_bridge_pkg.sv
// Shared definitions for the Xillybus <-> HLS ap_fifo stream bridge:
// session state encoding and parameter legality helpers.
package xillybus_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_EOF   = 2'd3
  } bridge_state_t;

  function automatic bit data_w_legal(input int w);
    return (w == 8) || (w == 16) || (w == 32) || (w == 64);
  endfunction

  // Depths must be powers of two so the pointers can wrap by overflow.
  function automatic bit depth_legal(input int d);
    return (d >= 4) && (d <= 4096) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/bridge_sync_fifo.sv
// Single-clock FIFO with inferred RAM and a registered read port.
// rd_data only changes on an accepted read, so it doubles as a holding register.
module bridge_sync_fifo
  import xillybus_bridge_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    wr_en,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("bridge_sync_fifo: DEPTH must be a power of two in 4..4096");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_reg;
  logic [AW-1:0]    rptr_reg;
  logic [LW-1:0]    level_reg;
  logic             wr_ok;
  logic             rd_ok;

  // Occupancy comes from the counter; pointer equality is ambiguous when full.
  assign full  = (level_reg == LW'(DEPTH));
  assign empty = (level_reg == '0);
  assign level = level_reg;
  assign wr_ok = wr_en && !full && !clr;
  assign rd_ok = rd_en && !empty && !clr;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      level_reg <= '0;
      rd_data   <= '0;
    end else if (clr) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      level_reg <= '0;
      rd_data   <= '0;
    end else begin
      if (wr_ok) begin
        wptr_reg <= wptr_reg + AW'(1);
      end
      if (rd_ok) begin
        rptr_reg <= rptr_reg + AW'(1);
        rd_data  <= mem[rptr_reg];
      end
      case ({wr_ok, rd_ok})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/xillybus_hls_stream_bridge.sv
// Bridges a Xillybus write/read stream pair to an HLS core's ap_fifo ports,
// with a session FSM that drains on write-close and flushes on read-close.
module xillybus_hls_stream_bridge
  import xillybus_bridge_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int IN_DEPTH  = 512,
  parameter int OUT_DEPTH = 512
) (
  input  logic                          bus_clk,
  input  logic                          bus_rst,
  input  logic                          user_w_wren,
  input  logic [DATA_W-1:0]             user_w_data,
  output logic                          user_w_full,
  input  logic                          user_w_open,
  input  logic                          user_r_rden,
  output logic [DATA_W-1:0]             user_r_data,
  output logic                          user_r_empty,
  output logic                          user_r_eof,
  input  logic                          user_r_open,
  output logic [DATA_W-1:0]             in_r_dout,
  output logic                          in_r_empty_n,
  input  logic                          in_r_read,
  input  logic [DATA_W-1:0]             out_r_din,
  output logic                          out_r_full_n,
  input  logic                          out_r_write,
  output logic                          core_rst,
  input  logic                          ap_idle,
  output logic [$clog2(IN_DEPTH):0]     in_level,
  output logic [$clog2(OUT_DEPTH):0]    out_level
);

  if (!data_w_legal(DATA_W)) begin : g_bad_data_w
    $error("xillybus_hls_stream_bridge: DATA_W must be 8, 16, 32 or 64");
  end

  bridge_state_t state_reg;
  bridge_state_t state_next;
  logic          core_rst_reg;
  logic          pf_valid_reg;
  logic          pf_valid_next;
  logic          active;
  logic          clr;
  logic          drained;
  logic          in_empty;
  logic          in_full;
  logic          out_empty;
  logic          out_full;
  logic          in_wr;
  logic          in_pop;
  logic          pf_take;
  logic          out_wr;
  logic          out_rd;

  // Traffic only moves while a session is live and not being torn down.
  assign active  = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign clr     = (state_next == ST_IDLE);
  assign drained = in_empty && !pf_valid_reg && out_empty && ap_idle;

  assign in_wr   = active && user_w_wren;
  assign pf_take = active && in_r_read && pf_valid_reg;
  assign in_pop  = active && !in_empty && (!pf_valid_reg || pf_take);
  assign out_wr  = active && out_r_write;
  assign out_rd  = active && user_r_rden;

  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      state_reg    <= ST_IDLE;
      core_rst_reg <= 1'b1;
      pf_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      core_rst_reg <= (state_next == ST_IDLE);
      pf_valid_reg <= pf_valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (user_w_open && user_r_open) state_next = ST_RUN;
      ST_RUN:   if (!user_w_open) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (user_w_open)  state_next = ST_RUN;
        else if (drained) state_next = ST_EOF;
      end
      ST_EOF:   state_next = ST_EOF;
      default:  state_next = ST_IDLE;
    endcase
    // Host closing the read side aborts the session from anywhere.
    if (!user_r_open) state_next = ST_IDLE;
  end

  // The input FIFO's read register is the prefetch word; this flag says it is live.
  always_comb begin
    pf_valid_next = pf_valid_reg;
    if (clr)          pf_valid_next = 1'b0;
    else if (in_pop)  pf_valid_next = 1'b1;
    else if (pf_take) pf_valid_next = 1'b0;
  end

  bridge_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (IN_DEPTH)
  ) u_in_fifo (
    .clk     (bus_clk),
    .rst     (bus_rst),
    .clr     (clr),
    .wr_en   (in_wr),
    .wr_data (user_w_data),
    .rd_en   (in_pop),
    .rd_data (in_r_dout),
    .level   (in_level),
    .full    (in_full),
    .empty   (in_empty)
  );

  bridge_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk     (bus_clk),
    .rst     (bus_rst),
    .clr     (clr),
    .wr_en   (out_wr),
    .wr_data (out_r_din),
    .rd_en   (out_rd),
    .rd_data (user_r_data),
    .level   (out_level),
    .full    (out_full),
    .empty   (out_empty)
  );

  assign core_rst     = core_rst_reg;
  assign in_r_empty_n = pf_valid_reg;
  assign user_w_full  = in_full;
  assign out_r_full_n = !out_full;
  assign user_r_empty = out_empty;
  assign user_r_eof   = (state_reg == ST_EOF);

endmodule

// File: tb/tb_xillybus_hls_stream_bridge.sv
// Directed scenarios for the stream bridge with scoreboard queues for both data paths.
module tb_xillybus_hls_stream_bridge;

  localparam int DW = 32;
  localparam int ID = 16;
  localparam int OD = 16;

  logic          bus_clk = 1'b0;
  logic          bus_rst;
  logic          user_w_wren;
  logic [DW-1:0] user_w_data;
  logic          user_w_full;
  logic          user_w_open;
  logic          user_r_rden;
  logic [DW-1:0] user_r_data;
  logic          user_r_empty;
  logic          user_r_eof;
  logic          user_r_open;
  logic [DW-1:0] in_r_dout;
  logic          in_r_empty_n;
  logic          in_r_read;
  logic [DW-1:0] out_r_din;
  logic          out_r_full_n;
  logic          out_r_write;
  logic          core_rst;
  logic          ap_idle;
  logic [$clog2(ID):0] in_level;
  logic [$clog2(OD):0] out_level;

  always #5 bus_clk = ~bus_clk;

  xillybus_hls_stream_bridge #(
    .DATA_W    (DW),
    .IN_DEPTH  (ID),
    .OUT_DEPTH (OD)
  ) dut (
    .bus_clk      (bus_clk),
    .bus_rst      (bus_rst),
    .user_w_wren  (user_w_wren),
    .user_w_data  (user_w_data),
    .user_w_full  (user_w_full),
    .user_w_open  (user_w_open),
    .user_r_rden  (user_r_rden),
    .user_r_data  (user_r_data),
    .user_r_empty (user_r_empty),
    .user_r_eof   (user_r_eof),
    .user_r_open  (user_r_open),
    .in_r_dout    (in_r_dout),
    .in_r_empty_n (in_r_empty_n),
    .in_r_read    (in_r_read),
    .out_r_din    (out_r_din),
    .out_r_full_n (out_r_full_n),
    .out_r_write  (out_r_write),
    .core_rst     (core_rst),
    .ap_idle      (ap_idle),
    .in_level     (in_level),
    .out_level    (out_level)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] out_q[$];

  task automatic step();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    $display("check %-20s observed 0x%0h expected 0x%0h", tag, obs, expv);
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_in_word(input string tag);
    if (exp_q.size() == 0) chk({tag, "_unexpected"}, 64'(in_r_empty_n), 64'(0));
    else                   chk(tag, 64'(in_r_dout), 64'(exp_q.pop_front()));
  endtask

  task automatic check_out_word(input string tag);
    if (out_q.size() == 0) chk({tag, "_unexpected"}, 64'(user_r_empty), 64'(1));
    else                   chk(tag, 64'(user_r_data), 64'(out_q.pop_front()));
  endtask

  initial begin
    int  bubbles;
    int  rx;
    int  model_lvl;
    bit  started;
    bit  rd_pending;

    bus_rst = 1'b1;
    user_w_wren = 0; user_w_data = '0; user_w_open = 0;
    user_r_rden = 0; user_r_open = 0;
    in_r_read = 0; out_r_din = '0; out_r_write = 0; ap_idle = 1;
    step(); step();

    // Reset values
    chk("rst_core_rst", 64'(core_rst), 1);
    chk("rst_w_full", 64'(user_w_full), 0);
    chk("rst_r_empty", 64'(user_r_empty), 1);
    chk("rst_r_eof", 64'(user_r_eof), 0);
    chk("rst_in_empty_n", 64'(in_r_empty_n), 0);
    chk("rst_out_full_n", 64'(out_r_full_n), 1);
    chk("rst_in_level", 64'(in_level), 0);
    chk("rst_out_level", 64'(out_level), 0);
    chk("rst_r_data", 64'(user_r_data), 0);
    bus_rst = 1'b0;
    step();
    chk("idle_after_rst", 64'(core_rst), 1);
    user_w_wren = 1; user_w_data = 32'hDEAD;
    step();
    user_w_wren = 0;
    chk("idle_wr_ignored", 64'(in_level), 0);

    // Open session, stream 1..8 with the core reading every cycle
    user_w_open = 1; user_r_open = 1;
    step();
    chk("run_core_rst", 64'(core_rst), 0);
    in_r_read = 1; bubbles = 0; started = 0; rx = 0;
    for (int c = 0; c < 14; c++) begin
      if (c < 8) begin
        user_w_wren = 1; user_w_data = DW'(c + 1); exp_q.push_back(DW'(c + 1));
      end else begin
        user_w_wren = 0;
      end
      if (in_r_empty_n) begin
        check_in_word("stream_word");
        started = 1; rx++;
      end else if (started && exp_q.size() > 0) begin
        bubbles++;
      end
      step();
    end
    in_r_read = 0;
    chk("stream_count", 64'(rx), 8);
    chk("stream_bubbles", 64'(bubbles), 0);
    chk("stream_in_level", 64'(in_level), 0);

    // Fill the input FIFO behind a held prefetch word
    user_w_wren = 1; user_w_data = 32'h100; exp_q.push_back(32'h100);
    step();
    user_w_wren = 0;
    step();
    chk("fill_pf_loaded", 64'(in_r_empty_n), 1);
    model_lvl = 0;
    for (int i = 0; i < ID + 1; i++) begin
      user_w_wren = 1; user_w_data = DW'(32'h200 + i);
      if (model_lvl < ID) begin
        exp_q.push_back(DW'(32'h200 + i));
        model_lvl++;
      end
      step();
      if (i == ID - 2) chk("fill_not_full", 64'(user_w_full), 0);
      if (i == ID - 1) chk("fill_full", 64'(user_w_full), 1);
    end
    user_w_wren = 0;
    chk("fill_level", 64'(in_level), ID);
    chk("fill_still_full", 64'(user_w_full), 1);
    in_r_read = 1;
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      if (in_r_empty_n) check_in_word("fill_word");
      step();
    end
    in_r_read = 0;
    chk("fill_drain_left", 64'(exp_q.size()), 0);
    chk("fill_drop_absent", 64'(in_r_empty_n), 0);

    // Output FIFO boundary, then the A5/5A host read timing
    model_lvl = 0;
    for (int i = 0; i < OD + 1; i++) begin
      out_r_write = 1; out_r_din = DW'(32'h300 + i);
      if (model_lvl < OD) begin
        out_q.push_back(DW'(32'h300 + i));
        model_lvl++;
      end
      step();
    end
    out_r_write = 0;
    chk("out_full_n", 64'(out_r_full_n), 0);
    chk("out_level_full", 64'(out_level), OD);
    user_r_rden = 1;
    for (int i = 0; i < OD; i++) begin
      step();
      check_out_word("out_fill_word");
    end
    user_r_rden = 0;
    chk("out_drop_absent", 64'(user_r_empty), 1);

    out_r_write = 1; out_r_din = 32'hA5; out_q.push_back(32'hA5);
    step();
    out_r_din = 32'h5A; out_q.push_back(32'h5A);
    step();
    out_r_write = 0;
    chk("ab_out_level", 64'(out_level), 2);
    chk("ab_not_empty", 64'(user_r_empty), 0);
    user_r_rden = 1;
    step();
    user_r_rden = 0;
    check_out_word("ab_first");
    step();
    chk("ab_hold", 64'(user_r_data), 32'hA5);
    user_r_rden = 1;
    step();
    check_out_word("ab_second");
    chk("ab_empty_after", 64'(user_r_empty), 1);
    step();
    user_r_rden = 0;
    chk("ab_rden_empty", 64'(user_r_data), 32'h5A);

    // Close write side with 3 words queued; core echoes, host drains
    ap_idle = 0;
    for (int i = 0; i < 3; i++) begin
      user_w_wren = 1; user_w_data = DW'(32'h11 * (i + 1)); out_q.push_back(DW'(32'h11 * (i + 1)));
      step();
    end
    user_w_wren = 0;
    user_w_open = 0;
    step();
    chk("drain_no_eof", 64'(user_r_eof), 0);
    chk("drain_in_kept", 64'(in_r_empty_n), 1);
    rx = 0; rd_pending = 0;
    for (int c = 0; c < 60; c++) begin
      if (rd_pending) begin
        check_out_word("echo_word");
        rx++; rd_pending = 0;
      end
      if (rx == 3) break;
      in_r_read = in_r_empty_n; out_r_write = in_r_empty_n; out_r_din = in_r_dout;
      user_r_rden = !user_r_empty; rd_pending = !user_r_empty;
      step();
    end
    in_r_read = 0; out_r_write = 0; user_r_rden = 0;
    chk("echo_count", 64'(rx), 3);
    step();
    chk("busy_no_eof", 64'(user_r_eof), 0);
    ap_idle = 1;
    step();
    chk("eof_set", 64'(user_r_eof), 1);
    chk("eof_r_empty", 64'(user_r_empty), 1);
    step();
    chk("eof_persist", 64'(user_r_eof), 1);
    chk("eof_core_rst", 64'(core_rst), 0);

    // Read-close returns to IDLE; reopen and abort with 10 words buffered
    user_r_open = 0;
    step();
    chk("close_idle_core_rst", 64'(core_rst), 1);
    chk("close_eof_clear", 64'(user_r_eof), 0);
    user_w_open = 1; user_r_open = 1;
    step();
    for (int i = 0; i < 10; i++) begin
      user_w_wren = 1; user_w_data = DW'(32'h400 + i);
      out_r_write = (i < 3); out_r_din = DW'(32'h500 + i);
      step();
    end
    user_w_wren = 0; out_r_write = 0;
    step(); step();
    chk("abort_in_level_pre", 64'(in_level), 9);
    chk("abort_out_level_pre", 64'(out_level), 3);
    user_r_open = 0;
    step();
    chk("abort_core_rst", 64'(core_rst), 1);
    chk("abort_in_level", 64'(in_level), 0);
    chk("abort_out_level", 64'(out_level), 0);
    chk("abort_eof", 64'(user_r_eof), 0);
    chk("abort_pf_clear", 64'(in_r_empty_n), 0);

    // Asynchronous reset during DRAIN
    user_r_open = 1;
    step();
    chk("reopen_core_rst", 64'(core_rst), 0);
    for (int i = 0; i < 4; i++) begin
      user_w_wren = 1; user_w_data = DW'(32'h600 + i);
      out_r_write = (i < 2); out_r_din = (i == 0) ? 32'hC3 : 32'h3C;
      step();
    end
    user_w_wren = 0; out_r_write = 0;
    out_q.push_back(32'hC3); out_q.push_back(32'h3C);
    step();
    user_r_rden = 1;
    step();
    user_r_rden = 0;
    check_out_word("pre_rst_word");
    user_w_open = 0;
    step();
    chk("pre_rst_drain", 64'(user_r_eof), 0);
    #2;
    bus_rst = 1'b1;
    #1;
    chk("arst_core_rst", 64'(core_rst), 1);
    chk("arst_w_full", 64'(user_w_full), 0);
    chk("arst_r_empty", 64'(user_r_empty), 1);
    chk("arst_r_eof", 64'(user_r_eof), 0);
    chk("arst_in_empty_n", 64'(in_r_empty_n), 0);
    chk("arst_out_full_n", 64'(out_r_full_n), 1);
    chk("arst_in_level", 64'(in_level), 0);
    chk("arst_out_level", 64'(out_level), 0);
    chk("arst_r_data", 64'(user_r_data), 0);
    out_q.delete();
    step();
    bus_rst = 1'b0;
    step();
    chk("post_rst_idle", 64'(core_rst), 1);
    chk("post_rst_in_level", 64'(in_level), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xillybus_hls_stream_bridge.md
XILLYBUS_HLS_STREAM_BRIDGE -- requirements
Module: xillybus_hls_stream_bridge

Interface
REQ-001 Parameter DATA_W, default 32, width of the stream word; legal values 8, 16, 32 and 64.
REQ-002 Parameter IN_DEPTH, default 512, input FIFO depth in words; must be a power of two, 4..4096.
REQ-003 Parameter OUT_DEPTH, default 512, output FIFO depth in words; same rules as IN_DEPTH.
REQ-004 Port bus_clk  in  1  is the single clock.
REQ-005 Port bus_rst  in  1  is the asynchronous, active-high reset.
REQ-006 Host-to-FPGA ports: user_w_wren in 1, user_w_data in DATA_W, user_w_full out 1, user_w_open in 1.
REQ-007 FPGA-to-host ports: user_r_rden in 1, user_r_data out DATA_W, user_r_empty out 1, user_r_eof out 1, user_r_open in 1.
REQ-008 Core input ap_fifo ports: in_r_dout out DATA_W, in_r_empty_n out 1, in_r_read in 1.
REQ-009 Core output ap_fifo ports: out_r_din in DATA_W, out_r_full_n out 1, out_r_write in 1.
REQ-010 Core control ports: core_rst out 1 (active-high reset to the HLS core), ap_idle in 1.
REQ-011 Status ports: in_level out clog2(IN_DEPTH)+1 and out_level out clog2(OUT_DEPTH)+1 give the live word counts.

Function
REQ-012 The input path SHALL use a standard FIFO followed by a one-word prefetch register; in_r_empty_n SHALL be 1 exactly when the prefetch register holds a word, and in_r_dout SHALL present that word.
REQ-013 The prefetch register SHALL load from the FIFO when the FIFO is non-empty and either the register is empty or in_r_read=1 in the same cycle, so back-to-back reads sustain one word per cycle.
REQ-014 in_r_read=1 while in_r_empty_n=0 SHALL be ignored.
REQ-015 user_w_full SHALL equal (in_level==IN_DEPTH); a user_w_wren while full SHALL be dropped with no state change.
REQ-016 in_level SHALL count FIFO words only, excluding the prefetch word; a simultaneous write and pop SHALL leave it unchanged.
REQ-017 out_r_full_n SHALL equal (out_level<OUT_DEPTH); out_r_write while out_r_full_n=0 SHALL be dropped.
REQ-018 On user_r_rden with user_r_empty=0, user_r_data SHALL be valid the following cycle and held until the next accepted read; rden while empty SHALL be ignored.
REQ-019 FIFO pointers SHALL wrap modulo depth; the full and empty conditions SHALL derive from the level counter, not from pointer equality.
REQ-020 The session FSM SHALL have the states IDLE, RUN, DRAIN and EOF.
REQ-021 FSM transitions: IDLE->RUN when user_w_open=1 and user_r_open=1; RUN->DRAIN when user_w_open falls; DRAIN->RUN when user_w_open rises again.
REQ-022 FSM transitions: DRAIN->EOF when the input FIFO is empty, the prefetch register is empty, the output FIFO is empty and ap_idle=1, all sampled in the same cycle.
REQ-023 FSM transitions: any state->IDLE in the cycle after user_r_open=0; this transition has priority over every other transition.
REQ-024 user_r_eof SHALL be 1 only in EOF, where user_r_empty is also 1; EOF SHALL persist until user_r_open=0.
REQ-025 In IDLE, both FIFOs, the prefetch register and the level counters SHALL be cleared synchronously, and writes and reads SHALL be ignored.
REQ-026 Closing the write side alone (RUN->DRAIN) SHALL NOT flush any data.
REQ-027 core_rst SHALL be a registered signal, equal to 1 in IDLE and 0 in RUN, DRAIN and EOF.

Reset
REQ-028 On bus_rst=1, asynchronously: FSM=IDLE, core_rst=1, user_w_full=0, user_r_empty=1, user_r_eof=0, in_r_empty_n=0, out_r_full_n=1, in_level=0, out_level=0, user_r_data=0.
REQ-029 Deasserting bus_rst SHALL leave the block in IDLE; asserting bus_rst mid-transfer SHALL discard all buffered data.

Structure
REQ-030 The FSM state encoding and the DATA_W legality check SHALL live in the shared package xillybus_bridge_pkg.
REQ-031 Both FIFOs SHALL be instances of one sub-module, bridge_sync_fifo (parameters WIDTH and DEPTH, inferred RAM, level output).

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- Both sides open, write 0x1..0x8, core reads every cycle -> in_r_dout returns 0x1..0x8 in order, no bubbles after the first word, in_level returns to 0.
- Fill with IN_DEPTH+1 writes while the core is stalled -> user_w_full=1 after IN_DEPTH writes, last word dropped, in_level=IN_DEPTH.
- Core writes 0xA5 and 0x5A, host rdens twice -> user_r_data=0xA5 then 0x5A, each one cycle after its rden, then user_r_empty=1.
- Close write with 3 words queued and core echoing them, ap_idle=1 once done -> all 3 words reach the host, then user_r_eof=1.
- Drop user_r_open mid-stream with 10 words buffered -> next cycle IDLE, core_rst=1, levels 0, user_r_eof=0.
- Assert bus_rst during DRAIN -> every output takes its REQ-028 value immediately, without waiting for a clock edge.
